// File: rtl/vm_pkg.sv
// Shared definitions for the coin payout unit.
//   - state_t       : payout FSM states
//   - DENOM_*       : coin values in units
//   - REFILL_SEL_*  : refill_sel encodings; these double as the inventory
//                     slot index, so slot 0 = 10, slot 1 = 5, slot 2 = 1
//   - EJ_BIT_*      : bit positions of each solenoid in coin_eject
package vm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int NUM_DENOM = 3;

  localparam int unsigned DENOM_10 = 10;
  localparam int unsigned DENOM_5  = 5;
  localparam int unsigned DENOM_1  = 1;

  localparam logic [1:0] REFILL_SEL_10 = 2'd0;
  localparam logic [1:0] REFILL_SEL_5  = 2'd1;
  localparam logic [1:0] REFILL_SEL_1  = 2'd2;

  localparam int EJ_BIT_10 = 2;
  localparam int EJ_BIT_5  = 1;
  localparam int EJ_BIT_1  = 0;

  // Coin value held in an inventory slot.
  function automatic int unsigned denom_value(input logic [1:0] slot);
    case (slot)
      REFILL_SEL_10: return DENOM_10;
      REFILL_SEL_5:  return DENOM_5;
      REFILL_SEL_1:  return DENOM_1;
      default:       return 0;
    endcase
  endfunction

  // One-hot solenoid drive for an inventory slot.
  function automatic logic [2:0] eject_mask(input logic [1:0] slot);
    logic [2:0] m;
    m = '0;
    case (slot)
      REFILL_SEL_10: m[EJ_BIT_10] = 1'b1;
      REFILL_SEL_5:  m[EJ_BIT_5]  = 1'b1;
      REFILL_SEL_1:  m[EJ_BIT_1]  = 1'b1;
      default:       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Request/response channel between the vending controller (master) and the
// change dispenser (slave).
//   req_valid/req_amount/req_ready : payout request handshake
//   done/short                     : completion pulse and shortfall flag
//   remaining                      : amount still owed
interface vm_change_dispenser_if #(
  parameter int AMT_W = 8
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remaining;

  modport master (
    output req_valid, req_amount,
    input  req_ready, done, short, remaining
  );

  modport slave (
    input  req_valid, req_amount,
    output req_ready, done, short, remaining
  );
endinterface

// File: rtl/vm_pulse_timer.sv
// Loadable down-counter with terminal-count flag. Loading N-1 makes tc
// assert on the N-th cycle after the load edge, which times both the
// solenoid on-time and the post-coin gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : value to load
//   tc         : count has reached zero
module vm_pulse_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);
endmodule

// File: rtl/vm_change_dispenser.sv
// Coin payout unit: pays a requested change amount greedily in 10/5/1 coins,
// pulsing one ejector solenoid per coin, and tracks per-denomination stock.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_if (slave)        : request handshake, done/short, remaining
//   refill_valid/sel/count: add coins to one inventory (sel 3 ignored)
//   coin_eject            : one-hot solenoid drive {10, 5, 1}
//   busy                  : FSM not idle
//   inv_10, inv_5, inv_1  : current inventories
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int INIT_INV     = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vm_change_dispenser_if.slave req_if,
  input  logic                 refill_valid,
  input  logic [1:0]           refill_sel,
  input  logic [AMT_W-1:0]     refill_count,
  output logic [2:0]           coin_eject,
  output logic                 busy,
  output logic [AMT_W-1:0]     inv_10,
  output logic [AMT_W-1:0]     inv_5,
  output logic [AMT_W-1:0]     inv_1
);
  localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int SUM_W   = AMT_W + 1;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  state_t           state_reg;
  logic [AMT_W-1:0] remaining_reg;
  logic [2:0]       coin_eject_reg;
  logic             done_reg;
  logic             short_reg;

  logic [AMT_W-1:0]     inv_cur [NUM_DENOM];
  logic [NUM_DENOM-1:0] qualify;
  logic                 pick_valid;
  logic [1:0]           pick_idx;
  logic [AMT_W-1:0]     pick_amt;
  logic                 take_coin;
  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_load_val;
  logic                 tmr_tc;

  // Inventory counters, one per slot. A refill and a payout decrement on the
  // same slot in the same cycle are merged into one saturating update.
  for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_denom
    logic [AMT_W-1:0] count_reg;
    logic             dec;
    logic             add;
    logic [SUM_W-1:0] sum_next;

    assign dec = take_coin && (pick_idx == 2'(gi));
    assign add = refill_valid && (refill_sel == 2'(gi));
    // dec only fires when count_reg > 0, so the subtraction cannot wrap.
    assign sum_next = {1'b0, count_reg} + (add ? {1'b0, refill_count} : SUM_W'(0))
                      - SUM_W'(dec);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_reg <= AMT_W'(INIT_INV);
      end else begin
        count_reg <= sum_next[AMT_W] ? '1 : sum_next[AMT_W-1:0];
      end
    end

    assign inv_cur[gi] = count_reg;
    assign qualify[gi] = (count_reg != '0) &&
                         (remaining_reg >= AMT_W'(denom_value(2'(gi))));
  end

  // Greedy pick: scan from the smallest coin up so the largest qualifying
  // denomination (lowest slot index) is written last and wins.
  always_comb begin
    pick_idx   = 2'd0;
    pick_valid = 1'b0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (qualify[i]) begin
        pick_idx   = 2'(i);
        pick_valid = 1'b1;
      end
    end
  end

  assign pick_amt  = AMT_W'(denom_value(pick_idx));
  assign take_coin = (state_reg == ST_SELECT) && (remaining_reg != '0) && pick_valid;

  assign tmr_load     = take_coin || ((state_reg == ST_EJECT) && tmr_tc && HAS_GAP);
  assign tmr_load_val = (state_reg == ST_SELECT) ? PULSE_LOAD : GAP_LOAD;

  vm_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      remaining_reg  <= '0;
      coin_eject_reg <= '0;
      done_reg       <= 1'b0;
      short_reg      <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      short_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_if.req_valid) begin
            remaining_reg <= req_if.req_amount;
            state_reg     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (remaining_reg == '0) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else if (!pick_valid) begin
            done_reg  <= 1'b1;
            short_reg <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            remaining_reg  <= remaining_reg - pick_amt;
            coin_eject_reg <= eject_mask(pick_idx);
            state_reg      <= ST_EJECT;
          end
        end
        ST_EJECT: begin
          if (tmr_tc) begin
            coin_eject_reg <= '0;
            state_reg      <= HAS_GAP ? ST_GAP : ST_SELECT;
          end
        end
        ST_GAP: begin
          if (tmr_tc) state_reg <= ST_SELECT;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready = (state_reg == ST_IDLE);
  assign req_if.done      = done_reg;
  assign req_if.short     = short_reg;
  assign req_if.remaining = remaining_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign coin_eject       = coin_eject_reg;
  assign inv_10           = inv_cur[0];
  assign inv_5            = inv_cur[1];
  assign inv_1            = inv_cur[2];
endmodule
